// File: rtl/cr_clic_cpu_intc_pkg.sv
// cr_clic_cpu_intc_pkg: shared encodings and helpers for the CLIC CPU-side interrupt controller
package cr_clic_cpu_intc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_VEC_RD,
        ST_VEC_DONE
    } intc_state_e;

    localparam logic [1:0] PRIV_M    = 2'b11;
    localparam logic [1:0] PRIV_U    = 2'b00;
    localparam int         VEC_ALIGN = 6;

    // Vector table entry address: table base aligned down, one word per interrupt ID
    function automatic logic [31:0] vec_entry_addr(input logic [31:0] mtvt, input logic [31:0] id);
        return {mtvt[31:VEC_ALIGN], {VEC_ALIGN{1'b0}}} + (id << 2);
    endfunction

    // Privilege enable for a request of privilege priv taken from mode
    function automatic logic priv_en(input logic [1:0] priv, input logic [1:0] mode,
                                     input logic mie, input logic uie);
        return priv == PRIV_M ? (mode != PRIV_M || mie) :
               priv == PRIV_U ? (mode == PRIV_U && uie) : 1'b0;
    endfunction

endpackage

// File: rtl/cr_clic_nest_stack.sv
// cr_clic_nest_stack: LIFO of preempted {level, id} pairs used for interrupt nesting
module cr_clic_nest_stack #(
    parameter  int ID_WIDTH   = 12,
    parameter  int NEST_DEPTH = 4,
    localparam int AW         = $clog2(NEST_DEPTH),
    localparam int DW         = AW + 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [7:0]          mil_i,
    input  logic [ID_WIDTH-1:0] id_i,
    output logic [7:0]          top_mil_o,
    output logic [ID_WIDTH-1:0] top_id_o,
    output logic [DW-1:0]       depth_o
);

    logic [7:0]          mil_q [NEST_DEPTH];
    logic [ID_WIDTH-1:0] id_q  [NEST_DEPTH];
    logic [DW-1:0]       depth_q;
    logic [AW-1:0]       wr_idx;
    logic [AW-1:0]       rd_idx;

    assign wr_idx    = depth_q[AW-1:0];
    assign rd_idx    = AW'(depth_q - DW'(1));
    assign top_mil_o = mil_q[rd_idx];
    assign top_id_o  = id_q[rd_idx];
    assign depth_o   = depth_q;

    // Push writes at the current occupancy; pop only moves the pointer back
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            depth_q <= '0;
            for (int i = 0; i < NEST_DEPTH; i++) begin
                mil_q[i] <= '0;
                id_q[i]  <= '0;
            end
        end else if (push_i) begin
            mil_q[wr_idx] <= mil_i;
            id_q[wr_idx]  <= id_i;
            depth_q       <= depth_q + DW'(1);
        end else if (pop_i) begin
            depth_q <= depth_q - DW'(1);
        end
    end

endmodule

// File: rtl/cr_clic_cpu_intc.sv
// cr_clic_cpu_intc: CPU-side CLIC receiver - qualifies requests, runs take/vector handshake, tracks nesting
module cr_clic_cpu_intc
    import cr_clic_cpu_intc_pkg::*;
#(
    parameter  int ID_WIDTH   = 12,
    parameter  int NEST_DEPTH = 4,
    localparam int DW         = $clog2(NEST_DEPTH) + 1
) (
    input  logic                cpuclk,
    input  logic                cpurst,
    input  logic                clic_cpu_int_hv,
    input  logic [ID_WIDTH-1:0] clic_cpu_int_id,
    input  logic [7:0]          clic_cpu_int_il,
    input  logic [1:0]          clic_cpu_int_priv,
    input  logic [1:0]          cpu_mode,
    input  logic                cpu_mie,
    input  logic                cpu_uie,
    input  logic                cpu_int_take,
    input  logic                cpu_mret_vld,
    input  logic [31:0]         cpu_mtvt,
    input  logic                vec_rd_ack,
    input  logic [31:0]         vec_rd_data,
    input  logic                vec_rd_err,
    output logic                intc_cpu_int_req,
    output logic [ID_WIDTH-1:0] intc_cpu_int_id,
    output logic [7:0]          intc_cpu_int_il,
    output logic [1:0]          intc_cpu_int_priv,
    output logic                intc_cpu_int_hv,
    output logic                vec_rd_req,
    output logic [31:0]         vec_rd_addr,
    output logic                intc_cpu_vec_vld,
    output logic [31:0]         intc_cpu_vec_pc,
    output logic                intc_cpu_vec_err,
    output logic [ID_WIDTH-1:0] cpu_clic_curid,
    output logic                cpu_clic_int_exit,
    output logic [7:0]          intc_cur_mil,
    output logic [DW-1:0]       intc_nest_depth
);

    intc_state_e         state_q, state_d;
    logic                snap_hv_q, snap_hv_d;
    logic [ID_WIDTH-1:0] snap_id_q, snap_id_d;
    logic [7:0]          snap_il_q, snap_il_d;
    logic [1:0]          snap_priv_q, snap_priv_d;
    logic                req_q, req_d;
    logic                vrd_req_q, vrd_req_d;
    logic [31:0]         vrd_addr_q, vrd_addr_d;
    logic                vld_q, vld_d;
    logic                verr_q, verr_d;
    logic [31:0]         pc_q, pc_d;
    logic                exit_q, exit_d;
    logic [7:0]          cur_mil_q, cur_mil_d;
    logic [ID_WIDTH-1:0] cur_id_q, cur_id_d;
    logic [7:0]          top_mil;
    logic [ID_WIDTH-1:0] top_id;
    logic                elig, take, mret_go, push, pop;

    assign elig = clic_cpu_int_il != 8'd0 && clic_cpu_int_il > cur_mil_q &&
                  intc_nest_depth < DW'(NEST_DEPTH) &&
                  priv_en(clic_cpu_int_priv, cpu_mode, cpu_mie, cpu_uie);
    assign take    = state_q == ST_REQ && cpu_int_take;
    assign mret_go = cpu_mret_vld && intc_nest_depth != '0 && !exit_q && !take;
    // A take landing on the exit cycle is pop-then-push of the same entry: stack untouched
    assign push = take && !exit_q;
    assign pop  = exit_q && !take;

    cr_clic_nest_stack #(
        .ID_WIDTH  (ID_WIDTH),
        .NEST_DEPTH(NEST_DEPTH)
    ) u_stack (
        .clk_i    (cpuclk),
        .rst_i    (cpurst),
        .push_i   (push),
        .pop_i    (pop),
        .mil_i    (cur_mil_q),
        .id_i     (cur_id_q),
        .top_mil_o(top_mil),
        .top_id_o (top_id),
        .depth_o  (intc_nest_depth)
    );

    // Next-state: request handshake, vector fetch, and current level/ID tracking
    always_comb begin
        state_d     = state_q;
        snap_hv_d   = snap_hv_q;
        snap_id_d   = snap_id_q;
        snap_il_d   = snap_il_q;
        snap_priv_d = snap_priv_q;
        vld_d       = 1'b0;
        verr_d      = 1'b0;
        pc_d        = '0;
        exit_d      = mret_go;
        cur_mil_d   = take ? snap_il_q : exit_q ? top_mil : cur_mil_q;
        cur_id_d    = take ? snap_id_q : exit_q ? top_id  : cur_id_q;
        case (state_q)
            ST_IDLE: begin
                if (elig) begin
                    snap_hv_d   = clic_cpu_int_hv;
                    snap_id_d   = clic_cpu_int_id;
                    snap_il_d   = clic_cpu_int_il;
                    snap_priv_d = clic_cpu_int_priv;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (take) state_d = snap_hv_q ? ST_VEC_RD : ST_IDLE;
                else if (!elig || clic_cpu_int_id != snap_id_q) state_d = ST_IDLE;
            end
            ST_VEC_RD: begin
                if (vec_rd_ack) begin
                    state_d = ST_VEC_DONE;
                    vld_d   = !vec_rd_err;
                    verr_d  = vec_rd_err;
                    pc_d    = vec_rd_err ? 32'h0 : (vec_rd_data & 32'hFFFF_FFFE);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_d      = state_d == ST_REQ;
        vrd_req_d  = state_d == ST_VEC_RD;
        vrd_addr_d = state_d != ST_VEC_RD ? 32'h0 :
                     state_q == ST_VEC_RD ? vrd_addr_q :
                     vec_entry_addr(cpu_mtvt, 32'(snap_id_q));
    end

    // State register and registered outputs
    always_ff @(posedge cpuclk) begin
        if (cpurst) begin
            state_q     <= ST_IDLE;
            snap_hv_q   <= 1'b0;
            snap_id_q   <= '0;
            snap_il_q   <= '0;
            snap_priv_q <= '0;
            req_q       <= 1'b0;
            vrd_req_q   <= 1'b0;
            vrd_addr_q  <= '0;
            vld_q       <= 1'b0;
            verr_q      <= 1'b0;
            pc_q        <= '0;
            exit_q      <= 1'b0;
            cur_mil_q   <= '0;
            cur_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            snap_hv_q   <= snap_hv_d;
            snap_id_q   <= snap_id_d;
            snap_il_q   <= snap_il_d;
            snap_priv_q <= snap_priv_d;
            req_q       <= req_d;
            vrd_req_q   <= vrd_req_d;
            vrd_addr_q  <= vrd_addr_d;
            vld_q       <= vld_d;
            verr_q      <= verr_d;
            pc_q        <= pc_d;
            exit_q      <= exit_d;
            cur_mil_q   <= cur_mil_d;
            cur_id_q    <= cur_id_d;
        end
    end

    assign intc_cpu_int_req  = req_q;
    assign intc_cpu_int_id   = snap_id_q;
    assign intc_cpu_int_il   = snap_il_q;
    assign intc_cpu_int_priv = snap_priv_q;
    assign intc_cpu_int_hv   = snap_hv_q;
    assign vec_rd_req        = vrd_req_q;
    assign vec_rd_addr       = vrd_addr_q;
    assign intc_cpu_vec_vld  = vld_q;
    assign intc_cpu_vec_pc   = pc_q;
    assign intc_cpu_vec_err  = verr_q;
    assign cpu_clic_curid    = cur_id_q;
    assign cpu_clic_int_exit = exit_q;
    assign intc_cur_mil      = cur_mil_q;

endmodule

// File: tb/tb_cr_clic_cpu_intc.sv
// tb_cr_clic_cpu_intc: directed and randomized checks against a transaction-level nesting model
module tb_cr_clic_cpu_intc;

    logic        cpuclk = 1'b0;
    logic        cpurst = 1'b1;
    logic        clic_cpu_int_hv = 1'b0;
    logic [11:0] clic_cpu_int_id = '0;
    logic [7:0]  clic_cpu_int_il = '0;
    logic [1:0]  clic_cpu_int_priv = '0;
    logic [1:0]  cpu_mode = '0;
    logic        cpu_mie = 1'b0;
    logic        cpu_uie = 1'b0;
    logic        cpu_int_take = 1'b0;
    logic        cpu_mret_vld = 1'b0;
    logic [31:0] cpu_mtvt = '0;
    logic        vec_rd_ack = 1'b0;
    logic [31:0] vec_rd_data = '0;
    logic        vec_rd_err = 1'b0;
    logic        intc_cpu_int_req;
    logic [11:0] intc_cpu_int_id;
    logic [7:0]  intc_cpu_int_il;
    logic [1:0]  intc_cpu_int_priv;
    logic        intc_cpu_int_hv;
    logic        vec_rd_req;
    logic [31:0] vec_rd_addr;
    logic        intc_cpu_vec_vld;
    logic [31:0] intc_cpu_vec_pc;
    logic        intc_cpu_vec_err;
    logic [11:0] cpu_clic_curid;
    logic        cpu_clic_int_exit;
    logic [7:0]  intc_cur_mil;
    logic [2:0]  intc_nest_depth;

    int checks = 0;
    int failures = 0;

    logic [7:0]  m_mil = '0;
    logic [11:0] m_id = '0;
    logic [19:0] m_stk[$];

    cr_clic_cpu_intc #(.ID_WIDTH(12), .NEST_DEPTH(4)) dut (
        .cpuclk(cpuclk), .cpurst(cpurst),
        .clic_cpu_int_hv(clic_cpu_int_hv), .clic_cpu_int_id(clic_cpu_int_id),
        .clic_cpu_int_il(clic_cpu_int_il), .clic_cpu_int_priv(clic_cpu_int_priv),
        .cpu_mode(cpu_mode), .cpu_mie(cpu_mie), .cpu_uie(cpu_uie),
        .cpu_int_take(cpu_int_take), .cpu_mret_vld(cpu_mret_vld), .cpu_mtvt(cpu_mtvt),
        .vec_rd_ack(vec_rd_ack), .vec_rd_data(vec_rd_data), .vec_rd_err(vec_rd_err),
        .intc_cpu_int_req(intc_cpu_int_req), .intc_cpu_int_id(intc_cpu_int_id),
        .intc_cpu_int_il(intc_cpu_int_il), .intc_cpu_int_priv(intc_cpu_int_priv),
        .intc_cpu_int_hv(intc_cpu_int_hv), .vec_rd_req(vec_rd_req), .vec_rd_addr(vec_rd_addr),
        .intc_cpu_vec_vld(intc_cpu_vec_vld), .intc_cpu_vec_pc(intc_cpu_vec_pc),
        .intc_cpu_vec_err(intc_cpu_vec_err), .cpu_clic_curid(cpu_clic_curid),
        .cpu_clic_int_exit(cpu_clic_int_exit), .intc_cur_mil(intc_cur_mil),
        .intc_nest_depth(intc_nest_depth)
    );

    always #5 cpuclk = ~cpuclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge cpuclk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_curid"}, 32'(cpu_clic_curid), 32'(m_id));
        chk({tag, "_mil"}, 32'(intc_cur_mil), 32'(m_mil));
        chk({tag, "_depth"}, 32'(intc_nest_depth), m_stk.size());
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_req"}, 32'(intc_cpu_int_req), 0);
        chk({tag, "_snap_id"}, 32'(intc_cpu_int_id), 0);
        chk({tag, "_snap_il"}, 32'(intc_cpu_int_il), 0);
        chk({tag, "_vrd_req"}, 32'(vec_rd_req), 0);
        chk({tag, "_vrd_addr"}, vec_rd_addr, 0);
        chk({tag, "_vld"}, 32'(intc_cpu_vec_vld), 0);
        chk({tag, "_pc"}, intc_cpu_vec_pc, 0);
        chk({tag, "_verr"}, 32'(intc_cpu_vec_err), 0);
        chk({tag, "_exit"}, 32'(cpu_clic_int_exit), 0);
        chk_model(tag);
    endtask

    // One interrupt presentation; expectations come from the eligibility rules and the model stack
    task automatic irq(input logic [1:0] priv, input logic [7:0] il, input logic [11:0] id,
                       input logic hv, input logic [1:0] mode, input logic mie, input logic uie,
                       input logic take, input logic [31:0] data, input logic err,
                       input int dly, input logic rst_vec);
        logic en, exp_req;
        logic [31:0] addr;
        en = priv == 2'b11 ? (mode != 2'b11 || mie) : priv == 2'b00 ? (mode == 2'b00 && uie) : 1'b0;
        exp_req = il != 0 && il > m_mil && m_stk.size() < 4 && en;
        clic_cpu_int_priv = priv;
        clic_cpu_int_il = il;
        clic_cpu_int_id = id;
        clic_cpu_int_hv = hv;
        cpu_mode = mode;
        cpu_mie = mie;
        cpu_uie = uie;
        step();
        chk("req", 32'(intc_cpu_int_req), 32'(exp_req));
        if (exp_req) begin
            chk("snap_id", 32'(intc_cpu_int_id), 32'(id));
            chk("snap_il", 32'(intc_cpu_int_il), 32'(il));
            chk("snap_priv", 32'(intc_cpu_int_priv), 32'(priv));
            chk("snap_hv", 32'(intc_cpu_int_hv), 32'(hv));
        end
        if (!exp_req || !take) begin
            clic_cpu_int_il = '0;
            step();
            chk("req_drop", 32'(intc_cpu_int_req), 0);
            return;
        end
        cpu_int_take = 1'b1;
        step();
        cpu_int_take = 1'b0;
        clic_cpu_int_il = '0;
        m_stk.push_back({m_mil, m_id});
        m_mil = il;
        m_id = id;
        chk("req_after_take", 32'(intc_cpu_int_req), 0);
        chk_model("take");
        if (!hv) return;
        addr = (cpu_mtvt & 32'hFFFF_FFC0) + 32'(id) * 4;
        chk("vrd_req", 32'(vec_rd_req), 1);
        chk("vrd_addr", vec_rd_addr, addr);
        for (int k = 0; k < dly; k++) begin
            step();
            chk("vrd_hold", 32'(vec_rd_req), 1);
        end
        if (rst_vec) begin
            cpurst = 1'b1;
            step();
            cpurst = 1'b0;
            m_stk.delete();
            m_mil = '0;
            m_id = '0;
            chk_rst("rst_vec");
            vec_rd_ack = 1'b1;
            vec_rd_data = data;
            step();
            vec_rd_ack = 1'b0;
            chk("late_ack_vld", 32'(intc_cpu_vec_vld), 0);
            chk("late_ack_err", 32'(intc_cpu_vec_err), 0);
            chk("late_ack_req", 32'(vec_rd_req), 0);
            return;
        end
        vec_rd_ack = 1'b1;
        vec_rd_data = data;
        vec_rd_err = err;
        step();
        vec_rd_ack = 1'b0;
        vec_rd_err = 1'b0;
        chk("vec_vld", 32'(intc_cpu_vec_vld), 32'(!err));
        chk("vec_err", 32'(intc_cpu_vec_err), 32'(err));
        chk("vec_pc", intc_cpu_vec_pc, err ? 32'h0 : (data & 32'hFFFF_FFFE));
        chk("vrd_req_done", 32'(vec_rd_req), 0);
        step();
        chk("vec_vld_pulse", 32'(intc_cpu_vec_vld), 0);
        chk("vec_err_pulse", 32'(intc_cpu_vec_err), 0);
    endtask

    // mret: exit pulse carries the exiting ID, then the model pops
    task automatic mret();
        cpu_mret_vld = 1'b1;
        step();
        cpu_mret_vld = 1'b0;
        chk("exit", 32'(cpu_clic_int_exit), 32'(m_stk.size() != 0));
        chk("exit_id", 32'(cpu_clic_curid), 32'(m_id));
        if (m_stk.size() != 0) {m_mil, m_id} = m_stk.pop_back();
        step();
        chk("exit_end", 32'(cpu_clic_int_exit), 0);
        chk_model("mret");
    endtask

    initial begin
        step();
        step();
        chk_rst("reset");
        cpurst = 1'b0;
        step();
        // basic take and exit, then mret with nothing active
        irq(2'b11, 8'h40, 12'd5, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0);
        mret();
        mret();
        // preemption: lower level blocked, higher level nests
        irq(2'b11, 8'h40, 12'd5, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0);
        irq(2'b11, 8'h30, 12'd6, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0);
        irq(2'b11, 8'h80, 12'd9, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0);
        // back-to-back mret: the second pulse lands on the exit cycle and is ignored
        cpu_mret_vld = 1'b1;
        step();
        chk("b2b_exit", 32'(cpu_clic_int_exit), 1);
        chk("b2b_exit_id", 32'(cpu_clic_curid), 9);
        step();
        cpu_mret_vld = 1'b0;
        {m_mil, m_id} = m_stk.pop_back();
        chk("b2b_second", 32'(cpu_clic_int_exit), 0);
        chk_model("b2b");
        mret();
        // hardware vectoring, good read then bus error
        cpu_mtvt = 32'h8000_0040;
        irq(2'b11, 8'h20, 12'd3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 32'h1235, 1'b0, 2, 1'b0);
        mret();
        irq(2'b11, 8'h20, 12'd3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 32'h1235, 1'b1, 0, 1'b0);
        mret();
        // withdrawal by ID switch, then take coincident with a switch
        clic_cpu_int_priv = 2'b11;
        clic_cpu_int_il = 8'h50;
        clic_cpu_int_id = 12'd7;
        clic_cpu_int_hv = 1'b0;
        cpu_mode = 2'b00;
        step();
        chk("wd_req", 32'(intc_cpu_int_req), 1);
        chk("wd_id7", 32'(intc_cpu_int_id), 7);
        clic_cpu_int_id = 12'd8;
        step();
        chk("wd_drop", 32'(intc_cpu_int_req), 0);
        step();
        chk("wd_rereq", 32'(intc_cpu_int_req), 1);
        chk("wd_id8", 32'(intc_cpu_int_id), 8);
        clic_cpu_int_il = '0;
        step();
        chk("wd_il_drop", 32'(intc_cpu_int_req), 0);
        clic_cpu_int_il = 8'h50;
        clic_cpu_int_id = 12'd7;
        step();
        chk("co_req", 32'(intc_cpu_int_req), 1);
        clic_cpu_int_id = 12'd8;
        cpu_int_take = 1'b1;
        step();
        cpu_int_take = 1'b0;
        clic_cpu_int_il = '0;
        m_stk.push_back({m_mil, m_id});
        m_mil = 8'h50;
        m_id = 12'd7;
        chk_model("co_take");
        step();
        chk("co_no_rereq", 32'(intc_cpu_int_req), 0);
        mret();
        // stack full blocks a higher level until an mret frees a slot
        for (int k = 1; k <= 4; k++)
            irq(2'b11, 8'(k * 16), 12'(k), 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0);
        irq(2'b11, 8'h80, 12'd10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0);
        mret();
        irq(2'b11, 8'h80, 12'd10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0);
        repeat (5) mret();
        // reset during an outstanding vector read, late ack ignored
        irq(2'b11, 8'h40, 12'd5, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0);
        irq(2'b11, 8'h60, 12'd11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 32'h4321, 1'b0, 1, 1'b1);
        // randomized mix of requests and returns
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) < 4) mret();
            else begin
                cpu_mtvt = $urandom;
                irq(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 12'($urandom_range(0, 4095)),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom,
                    $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)), 1'b0);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cr_clic_cpu_intc.md
Name: cr_clic_cpu_intc

Overview:
- CPU-side receiver of the CLIC interrupt interface.
- Qualifies the registered CLIC request (hv/id/il/priv) against the current interrupt level and the privilege enables.
- Runs the take handshake with the pipeline and, for hardware-vectored interrupts, fetches the vector-table entry.
- Keeps a nesting stack of preempted levels/IDs, and returns cpu_clic_curid / cpu_clic_int_exit to the CLIC on mret.

Parameters:
- ID_WIDTH, 12, interrupt ID width.
- NEST_DEPTH, 4, number of preemption stack entries (power of 2, ≥2).

Ports:
- cpuclk  in  1  clock
- cpurst  in  1  reset; synchronous, active-high
- clic_cpu_int_hv  in  1  selected interrupt is hardware-vectored
- clic_cpu_int_id  in  ID_WIDTH  selected interrupt ID
- clic_cpu_int_il  in  8  level; 0 = below threshold / none
- clic_cpu_int_priv  in  2  11 = M, 00 = U
- cpu_mode  in  2  current privilege, 11 = M, 00 = U
- cpu_mie  in  1  mstatus.MIE
- cpu_uie  in  1  ustatus.UIE
- cpu_int_take  in  1  pipeline accepts the pending request
- cpu_mret_vld  in  1  mret/uret retired (1-cycle pulse)
- cpu_mtvt  in  32  vector table base
- vec_rd_ack  in  1  vector read complete
- vec_rd_data  in  32  vector entry
- vec_rd_err  in  1  bus error on vector read
- intc_cpu_int_req  out  1  interrupt request to pipeline
- intc_cpu_int_id  out  ID_WIDTH  snapshot ID
- intc_cpu_int_il  out  8  snapshot level
- intc_cpu_int_priv  out  2  snapshot privilege
- intc_cpu_int_hv  out  1  snapshot hv
- vec_rd_req  out  1  vector read request
- vec_rd_addr  out  32  vector read address
- intc_cpu_vec_vld  out  1  vector PC valid (pulse)
- intc_cpu_vec_pc  out  32  vector target PC
- intc_cpu_vec_err  out  1  vector fetch error (pulse)
- cpu_clic_curid  out  ID_WIDTH  ID of active interrupt, 0 when none
- cpu_clic_int_exit  out  1  interrupt exit pulse to CLIC
- intc_cur_mil  out  8  mintstatus level (CSR read)
- intc_nest_depth  out  log2(NEST_DEPTH)+1  stack occupancy

Behaviour:
- Reset: all outputs 0, FSM IDLE, stack empty, cur_mil 0, cur_id 0.
- Eligibility (combinational), elig = il≠0 AND il>cur_mil AND depth<NEST_DEPTH AND en, where:
  - M interrupt: en = (cpu_mode≠11) OR cpu_mie.
  - U interrupt: en = (cpu_mode==00) AND cpu_uie.
  - Any other priv: not eligible.
- FSM states: IDLE, REQ, VEC_RD, VEC_DONE.
- IDLE: if elig, snapshot hv/id/il/priv; next cycle intc_cpu_int_req=1, state REQ (1-cycle latency).
- REQ:
  - cpu_int_take=1 → push {cur_mil, cur_id}; cur_mil←il; cur_id←id; req deasserts next cycle. Then go to VEC_RD if hv, else IDLE.
  - take=0 and input no longer elig, or input id≠snapshot id → drop req, go to IDLE (re-arbitrate next cycle).
  - take in the same cycle as a withdrawal: take wins, using the snapshot.
- VEC_RD:
  - vec_rd_req=1, vec_rd_addr = {cpu_mtvt[31:6],6'b0} + (id<<2), 32-bit wrap.
  - Request held until vec_rd_ack; data/err are sampled on ack.
- VEC_DONE (1 cycle):
  - Not err → intc_cpu_vec_vld=1, intc_cpu_vec_pc = data with bit0 cleared.
  - err → intc_cpu_vec_err=1, pc=0.
  - Return to IDLE.
- The FSM does not request while in VEC_RD/VEC_DONE.
- mret handling:
  - depth>0, mret at cycle T → cycle T+1: cpu_clic_int_exit=1 with cpu_clic_curid = exiting ID.
  - Edge ending T+1: pop into cur_mil/cur_id; exit returns to 0.
  - depth=0: no exit pulse, no state change.
  - mret while exit=1 (back-to-back): ignored.
  - mret and take in the same cycle: contract violation; take processed, mret ignored.
  - mret in REQ: pop proceeds; elig recomputed with the new cur_mil; snapshot withdrawal rules apply.
- Stack: LIFO, no overflow, because elig blocks requests when full.
- Outputs: cpu_clic_curid = cur_id; intc_cur_mil = cur_mil; all outputs registered.
- Reset mid-operation (incl. outstanding vector read): immediate return to reset state. A late vec_rd_ack is ignored in IDLE.

Decomposition:
- Shared package: FSM state encoding, PRIV_M=2'b11, PRIV_U=2'b00, vector alignment constant (6).
- Sub-module cr_clic_nest_stack: parameterised LIFO holding {mil[7:0], id[ID_WIDTH-1:0]}; push/pop/depth/top.

Test Plan:
- Basic take: cpu_mode=00, mie=0, M irq id=5 il=0x40 → req next cycle; take → cur_mil=0x40, curid=5, depth=1; mret → exit pulse with curid=5, then curid=0, mil=0.
- Preemption: active il=0x40; input il=0x30 → no req. Input il=0x80 id=9 → req; take → depth=2, curid=9; two mrets → curid 9→5→0 with exits on each.
- Hardware vectoring: hv=1 id=3, mtvt=0x8000_0040 → vec_rd_addr=0x8000_004C. ack with data=0x1235 → vec_vld=1, pc=0x1234. ack with err → vec_err=1.
- Withdrawal: req pending id=7, input switches to id=8 without take → req drops, re-requests id=8 two cycles later. Take coincident with switch → id 7 accepted.
- Stack full: NEST_DEPTH=4, four nested takes at increasing il → fifth higher-level irq gets no req until an mret.
- Reset/edge cases: mret with depth=0 → no exit pulse. cpurst during VEC_RD → all outputs 0 next cycle; late ack → no vec_vld.
